// File: rtl/inst_cache_if.sv
// Fetch-port and burst-read-port bundle for inst_cache.
// The slave modport is the cache's view; master is the CPU/memory side.
interface inst_cache_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_instr;
  logic        cpu_ready;
  logic        invalidate;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  cpu_req, cpu_addr, invalidate, mem_ack, mem_rdata, mem_rvalid,
    output cpu_instr, cpu_ready, mem_req, mem_addr, hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_addr, invalidate, mem_ack, mem_rdata, mem_rvalid,
    input  cpu_instr, cpu_ready, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache. Hits answer one cycle after the
// lookup; misses burst the whole line from memory, fill it and then answer.
module inst_cache #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LINES      = 64
) (
  input  logic          clock,
  input  logic          reset,
  inst_cache_if.slave   bus
);

  localparam int unsigned WB = $clog2(LINE_WORDS);
  localparam int unsigned OB = WB + 2;
  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned TW = 32 - OB - IB;
  localparam logic [WB-1:0] LAST_BEAT = WB'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, MREQ, FILL, RESP} state_t;

  state_t state, state_next;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];
  logic [31:0]      data [LINES*LINE_WORDS];

  logic [31:0]   cpu_instr;
  logic          cpu_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
  logic [WB-1:0] beat_cnt;
  logic [WB-1:0] req_off;
  logic          fill_inv;

  // lookup fields come straight from the CPU address; fill fields from the
  // latched line address so the fill never depends on cpu_addr
  logic [WB-1:0]    lk_off;
  logic [IB-1:0]    lk_idx;
  logic [TW-1:0]    lk_tag;
  logic [IB+WB-1:0] lk_line;
  logic [IB-1:0]    f_idx;
  logic [TW-1:0]    f_tag;
  logic             hit;
  logic             last_beat;
  logic             unused_addr_bits;

  assign lk_off    = bus.cpu_addr[OB-1:2];
  assign lk_idx    = bus.cpu_addr[OB+IB-1:OB];
  assign lk_tag    = bus.cpu_addr[31:OB+IB];
  assign lk_line   = {lk_idx, lk_off};
  assign f_idx     = mem_addr[OB+IB-1:OB];
  assign f_tag     = mem_addr[31:OB+IB];
  assign hit       = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign last_beat = bus.mem_rvalid && (beat_cnt == LAST_BEAT);
  assign unused_addr_bits = &{1'b0, bus.cpu_addr[1:0]};

  assign bus.cpu_instr  = cpu_instr;
  assign bus.cpu_ready  = cpu_ready;
  assign bus.mem_req    = (state == MREQ);
  assign bus.mem_addr   = mem_addr;
  assign bus.hit_count  = hit_count;
  assign bus.miss_count = miss_count;

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.cpu_req) state_next = hit ? RESP : MREQ;
      MREQ: if (bus.mem_ack) state_next = FILL;
      FILL: if (last_beat)   state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // control registers: valid bits, response, counters, fill bookkeeping
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid      <= '0;
      cpu_ready  <= 1'b0;
      cpu_instr  <= '0;
      mem_addr   <= '0;
      beat_cnt   <= '0;
      req_off    <= '0;
      fill_inv   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready <= (state_next == RESP);
      case (state)
        IDLE: if (bus.cpu_req) begin
          if (hit) begin
            cpu_instr <= data[lk_line];
            hit_count <= hit_count + 32'd1;
          end else begin
            mem_addr      <= {bus.cpu_addr[31:OB], {OB{1'b0}}};
            req_off       <= lk_off;
            fill_inv      <= 1'b0;
            valid[lk_idx] <= 1'b0;
            miss_count    <= miss_count + 32'd1;
          end
        end
        FILL: if (bus.mem_rvalid) begin
          beat_cnt <= beat_cnt + WB'(1);
          if (beat_cnt == req_off) cpu_instr <= bus.mem_rdata;
          if (last_beat) valid[f_idx] <= !fill_inv;
        end
        default: ;
      endcase
      // placed last so a flush wins over a line being marked valid this cycle
      if (bus.invalidate) begin
        valid <= '0;
        if (state == MREQ || state == FILL) fill_inv <= 1'b1;
      end
    end
  end

  // data and tag arrays: written only by fill beats, never reset
  always_ff @(posedge clock) begin
    if (reset && state == FILL && bus.mem_rvalid) begin
      data[{f_idx, beat_cnt}] <= bus.mem_rdata;
      if (beat_cnt == LAST_BEAT) tags[f_idx] <= f_tag;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus random fetches
// against a line-level reference model of the cache contents.
module tb_inst_cache;
  localparam int unsigned LW = 4;
  localparam int unsigned NL = 64;
  localparam int unsigned LINE_BYTES = LW * 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  inst_cache_if bus();

  inst_cache #(.LINE_WORDS(LW), .LINES(NL)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] mem_pre [logic [31:0]];
  bit          ref_valid [NL];
  logic [31:0] ref_tag [NL];
  logic [31:0] ref_hits;
  logic [31:0] ref_misses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_pre.exists(a)) return mem_pre[a];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
    ref_hits = 0;
    ref_misses = 0;
  endtask

  task automatic model_flush();
    for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.cpu_req = 1'b0;
    bus.invalidate = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rvalid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // One CPU fetch with the bench acting as memory. Called at posedge+1.
  task automatic fetch(input logic [31:0] addr, input int ack_wait, input int gap_pct,
                       input int inv_at_beat, input bit inv_at_lookup, input int rst_at_beat,
                       output int lat);
    logic [31:0] line, tag, exp_word;
    int unsigned idx;
    bit exp_hit, acked, done, inv_seen, addr_checked, rst_done;
    int edges, beats, ack_left, last_beat_edge;
    line = addr - (addr % LINE_BYTES);
    idx  = (addr / LINE_BYTES) % NL;
    tag  = addr / (LINE_BYTES * NL);
    exp_word = mem_word(addr - (addr % 4));
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
    acked = 0; done = 0; inv_seen = 0; addr_checked = 0; rst_done = 0;
    edges = 0; beats = 0; ack_left = ack_wait; last_beat_edge = -1; lat = -1;

    bus.cpu_req = 1'b1;
    bus.cpu_addr = addr;
    bus.invalidate = inv_at_lookup;
    if (exp_hit) ref_hits++;
    else begin
      ref_misses++;
      ref_valid[idx] = 1'b0;
    end
    if (inv_at_lookup) model_flush();

    while (!done) begin
      @(posedge clock);
      #1;
      edges++;
      bus.invalidate = 1'b0;
      bus.mem_ack = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata = $urandom;
      if (edges > 300) begin
        vectors++; miscompares++;
        $display("FAIL timeout addr=%h: no cpu_ready within 300 cycles, required one", addr);
        bus.cpu_req = 1'b0;
        apply_reset();
        return;
      end
      if (bus.cpu_ready) begin
        lat = edges;
        vectors++;
        if (bus.cpu_instr !== exp_word) begin
          miscompares++;
          $display("FAIL instr addr=%h: got %h, required %h", addr, bus.cpu_instr, exp_word);
        end
        vectors++;
        if (edges !== (exp_hit ? 1 : last_beat_edge + 1)) begin
          miscompares++;
          $display("FAIL latency addr=%h hit=%0d: got %0d, required %0d", addr, exp_hit, edges,
                   exp_hit ? 1 : last_beat_edge + 1);
        end
        vectors++;
        if (bus.hit_count !== ref_hits) begin
          miscompares++;
          $display("FAIL hit_count addr=%h: got %0d, required %0d", addr, bus.hit_count, ref_hits);
        end
        vectors++;
        if (bus.miss_count !== ref_misses) begin
          miscompares++;
          $display("FAIL miss_count addr=%h: got %0d, required %0d", addr, bus.miss_count, ref_misses);
        end
        if (!exp_hit) begin
          ref_tag[idx] = tag;
          ref_valid[idx] = !inv_seen;
        end
        bus.cpu_req = 1'b0;
        done = 1;
      end else if (bus.mem_req) begin
        if (exp_hit || acked) begin
          vectors++; miscompares++;
          $display("FAIL mem_req addr=%h: got 1, required 0 (hit=%0d acked=%0d)", addr, exp_hit, acked);
        end
        if (!addr_checked) begin
          addr_checked = 1;
          vectors++;
          if (bus.mem_addr !== line) begin
            miscompares++;
            $display("FAIL mem_addr addr=%h: got %h, required %h", addr, bus.mem_addr, line);
          end
        end
        if (!acked) begin
          if (ack_left == 0) begin
            bus.mem_ack = 1'b1;
            acked = 1;
          end else begin
            ack_left--;
            bus.mem_rvalid = ($urandom_range(1, 0) == 1);
          end
        end
      end else if (acked) begin
        if (rst_at_beat >= 0 && beats == rst_at_beat) begin
          reset = 1'b0;
          bus.cpu_req = 1'b0;
          bus.mem_rvalid = 1'b1;
          @(posedge clock);
          #1;
          bus.mem_rvalid = 1'b0;
          vectors++;
          if (bus.mem_req !== 1'b0 || bus.cpu_ready !== 1'b0 || bus.cpu_instr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_fill: got mem_req=%b cpu_ready=%b cpu_instr=%h, required 0/0/0",
                     bus.mem_req, bus.cpu_ready, bus.cpu_instr);
          end
          vectors++;
          if (bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_fill_counts: got %0d/%0d, required 0/0", bus.hit_count, bus.miss_count);
          end
          reset = 1'b1;
          model_reset();
          rst_done = 1;
          done = 1;
        end else begin
          if (inv_at_beat >= 0 && beats == inv_at_beat && !inv_seen) begin
            bus.invalidate = 1'b1;
            inv_seen = 1;
            model_flush();
          end
          if (beats < LW && $urandom_range(99, 0) >= gap_pct) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = mem_word(line + 32'(beats * 4));
            beats++;
            if (beats == LW) last_beat_edge = edges;
          end
        end
      end else if (exp_hit) begin
        vectors++; miscompares++;
        $display("FAIL hit_ready addr=%h: got cpu_ready=0 at cycle %0d, required 1", addr, edges);
      end
    end

    if (!rst_done) begin
      @(posedge clock);
      #1;
      vectors++;
      if (bus.cpu_ready !== 1'b0 || bus.mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_pulse addr=%h: got cpu_ready=%b mem_req=%b, required 0/0",
                 addr, bus.cpu_ready, bus.mem_req);
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    bus.cpu_addr = '0;
    bus.mem_rdata = '0;
    reset = 1'b0;
    bus.cpu_req = 1'b0;
    bus.invalidate = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rvalid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if (bus.cpu_ready !== 1'b0 || bus.cpu_instr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_cpu: got ready=%b instr=%h, required 0/0", bus.cpu_ready, bus.cpu_instr);
    end
    vectors++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mem: got req=%b addr=%h, required 0/0", bus.mem_req, bus.mem_addr);
    end
    vectors++;
    if (bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_counts: got %0d/%0d, required 0/0", bus.hit_count, bus.miss_count);
    end
    reset = 1'b1;
    model_reset();
    fetch(32'h0040_0000, 0, 0, -1, 0, -1, lat);
    vectors++;
    if (bus.miss_count !== 32'd1) begin
      miscompares++;
      $display("FAIL first_fetch_miss: got miss_count=%0d, required 1", bus.miss_count);
    end
  endtask

  task automatic test_cold_miss();
    int lat;
    apply_reset();
    fetch(32'h0040_0008, 0, 0, -1, 0, -1, lat);
    // 6 edges from request to cpu_ready: lookup, MREQ, 4 beats (7 cycles incl. RESP)
    vectors++;
    if (lat !== LW + 2) begin
      miscompares++;
      $display("FAIL cold_miss_latency: got %0d, required %0d", lat, LW + 2);
    end
    vectors++;
    if (bus.cpu_instr !== 32'hA2 || bus.miss_count !== 32'd1) begin
      miscompares++;
      $display("FAIL cold_miss_result: got instr=%h misses=%0d, required 000000a2/1",
               bus.cpu_instr, bus.miss_count);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    fetch(32'h0040_0000, 0, 0, -1, 0, -1, lat);
    vectors++;
    if (lat !== 1 || bus.cpu_instr !== 32'hA0) begin
      miscompares++;
      $display("FAIL hit0: got lat=%0d instr=%h, required 1/000000a0", lat, bus.cpu_instr);
    end
    fetch(32'h0040_000C, 0, 0, -1, 0, -1, lat);
    vectors++;
    if (lat !== 1 || bus.cpu_instr !== 32'hA3) begin
      miscompares++;
      $display("FAIL hit3: got lat=%0d instr=%h, required 1/000000a3", lat, bus.cpu_instr);
    end
    vectors++;
    if (bus.hit_count !== 32'd2 || bus.miss_count !== 32'd1) begin
      miscompares++;
      $display("FAIL hit_counts: got %0d/%0d, required 2/1", bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_conflict();
    int lat;
    fetch(32'h0040_0400, 1, 0, -1, 0, -1, lat);
    fetch(32'h0040_0000, 2, 25, -1, 0, -1, lat);
    vectors++;
    if (bus.miss_count !== 32'd3 || lat === 1) begin
      miscompares++;
      $display("FAIL conflict: got misses=%0d lat=%0d, required 3 misses and a miss latency",
               bus.miss_count, lat);
    end
  endtask

  task automatic test_invalidate();
    int lat;
    logic [31:0] m;
    fetch(32'h0040_0404, 0, 0, 1, 0, -1, lat);
    m = bus.miss_count;
    fetch(32'h0040_0404, 0, 0, -1, 0, -1, lat);
    vectors++;
    if (bus.miss_count !== m + 32'd1) begin
      miscompares++;
      $display("FAIL inv_fill_refetch: got misses=%0d, required %0d", bus.miss_count, m + 32'd1);
    end
    // a flush coinciding with a hit lookup still returns the hit
    fetch(32'h0040_0408, 0, 0, -1, 1, -1, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL inv_lookup_hit: got lat=%0d, required 1", lat);
    end
    fetch(32'h0040_0408, 0, 0, -1, 0, -1, lat);
  endtask

  task automatic test_reset_mid_fill();
    int lat;
    fetch(32'h0040_1234, 0, 0, -1, 0, 2, lat);
    fetch(32'h0040_1234, 0, 0, -1, 0, -1, lat);
    vectors++;
    if (bus.miss_count !== 32'd1 || bus.hit_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_refetch: got %0d/%0d, required misses=1 hits=0", bus.miss_count, bus.hit_count);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] a;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(19, 0) == 0) begin
        bus.invalidate = 1'b1;
        model_flush();
        @(posedge clock);
        #1;
        bus.invalidate = 1'b0;
        vectors++;
        if (bus.cpu_ready !== 1'b0 || bus.hit_count !== ref_hits || bus.miss_count !== ref_misses) begin
          miscompares++;
          $display("FAIL idle_hold: got ready=%b %0d/%0d, required 0 %0d/%0d",
                   bus.cpu_ready, bus.hit_count, bus.miss_count, ref_hits, ref_misses);
        end
      end
      a = 32'h0040_0000 + ($urandom_range(3, 0) << 10) + ($urandom_range(7, 0) << 4)
          + ($urandom_range(3, 0) << 2) + $urandom_range(3, 0);
      fetch(a, $urandom_range(2, 0), $urandom_range(40, 0),
            ($urandom_range(9, 0) == 0) ? int'($urandom_range(LW - 1, 0)) : -1,
            ($urandom_range(19, 0) == 0), -1, lat);
    end
  endtask

  initial begin
    for (int w = 0; w < LW; w++) mem_pre[32'h0040_0000 + 32'(w * 4)] = 32'hA0 + 32'(w);
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_invalidate();
    test_reset_mid_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the multicycle CPU's fetch port (PC out, instruction in) and the DDR memory controller's burst-read port. On a hit it returns the instruction word one cycle after the request. On a miss it fetches the whole line from memory in order, fills the line, then returns the requested word. It also keeps hit and miss counters for performance checks on the SD/DDR platform.

## Interface
Parameters:
- LINE_WORDS, 4: 32-bit words per line; power of two, 2 or more.
- LINES, 64: number of lines; power of two.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-low (0 = reset), sampled on the clock edge.
- cpu_req  in  1  fetch request; held high with a stable cpu_addr until cpu_ready.
- cpu_addr  in  32  byte address (the PC); bits [1:0] are ignored.
- cpu_instr  out  32  instruction word; valid only while cpu_ready=1.
- cpu_ready  out  1  one-cycle pulse: the fetch is complete.
- invalidate  in  1  pulse; clears every valid bit.
- mem_req  out  1  burst-read request; held high until mem_ack.
- mem_addr  out  32  line-aligned byte address of the burst.
- mem_ack  in  1  controller has accepted the request.
- mem_rdata  in  32  burst data beat.
- mem_rvalid  in  1  mem_rdata is valid; beats arrive in ascending word order.
- hit_count  out  32  number of hits; wraps at 2^32.
- miss_count  out  32  number of misses; wraps at 2^32.

## Operation
- Address split, with OB = log2(LINE_WORDS)+2 and IB = log2(LINES):
  - word offset = addr[OB-1:2]
  - index = addr[OB+IB-1:OB]
  - tag = addr[31:OB+IB]
  - Defaults: offset [3:2], index [9:4], tag [31:10].
- Storage: valid bit and tag per line, held in registers; data array of LINES×LINE_WORDS words.
- State machine has four states: IDLE, MREQ, FILL, RESP.
- IDLE, with cpu_req=1: look up the line.
  - Hit (valid and tag equal): register the word, increment hit_count, go to RESP.
  - Miss: latch the address, increment miss_count, clear the line's valid bit, go to MREQ.
- MREQ: drive mem_req=1 with mem_addr = {cpu_addr[31:OB], OB'b0}. When mem_ack=1, go to FILL; mem_req drops in the next cycle.
- FILL: each mem_rvalid beat is written to word beat_cnt of the line, and beat_cnt increments. On the beat whose offset matches the request, that word is also captured into the cpu_instr register. After beat LINE_WORDS-1: write the tag, set valid (unless suppressed, see below), go to RESP.
- RESP: cpu_ready=1 for one cycle with cpu_instr driven, then go to IDLE.
- mem_rvalid outside FILL is ignored.
- invalidate:
  - Clears all valid bits in the cycle it is sampled, in any state.
  - In the same cycle as a hit lookup in IDLE, the lookup still completes as a hit.
  - During MREQ or FILL, the fill completes and the CPU receives its word, but the filled line is left invalid.
- In IDLE with cpu_req=0, outputs hold and counters do not change.

## Timing
- Reset values:
  - state = IDLE
  - all valid bits = 0
  - cpu_ready = 0, cpu_instr = 0
  - mem_req = 0, mem_addr = 0
  - beat_cnt = 0
  - hit_count = 0, miss_count = 0
  - The data and tag arrays are not reset.
- Reset mid-miss: the block returns to IDLE on the next edge with mem_req=0. The memory controller shares the same reset, so no stale beats are expected; any that arrive are ignored.
- Hit latency: request seen at edge N, cpu_ready high during cycle N+1, back in IDLE at N+2. Back-to-back hits sustain one fetch every 2 cycles.
- Miss latency: 1 lookup cycle + MREQ cycles (≥1, until mem_ack) + LINE_WORDS beat cycles (plus any gaps in mem_rvalid) + 1 RESP cycle. With zero-wait memory and LINE_WORDS=4 this is 7 cycles.
- Outputs are registered, except that mem_addr and mem_req come directly from state registers. There is no combinational path from cpu_* inputs to mem_* outputs.
- hit_count and miss_count update on the edge that leaves IDLE.

## Test plan
- Reset with reset=0 held for 2 cycles → all outputs 0, hit_count=0, miss_count=0; then a request for 0x00400000 → miss.
- Cold miss at 0x00400008, memory returns beats 0xA0,0xA1,0xA2,0xA3 with mem_ack one cycle after mem_req:
  - mem_addr=0x00400000
  - cpu_instr=0xA2 with cpu_ready 7 cycles after the request
  - miss_count=1
- Follow-up requests at 0x00400000 and then 0x0040000C → hits returning 0xA0 and 0xA3, each with 1-cycle latency; hit_count=2, miss_count unchanged.
- Conflict: 0x00400400 maps to the same index as 0x00400000 → miss and refill; a later request for 0x00400000 → miss again; miss_count=3.
- invalidate pulse during FILL → the CPU still receives the correct word; a repeat request for the same address → miss.
- reset=0 asserted in the middle of FILL after 2 beats → next edge state=IDLE, mem_req=0; the same address requested afterwards → miss (line not valid).
